// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path and the clock-counter stage.
//   rx_state_t       : receiver FSM state encoding
//   UART_OVERSAMPLE  : oversample ticks per bit (default receiver parameter)
//   UART_DATA_BITS   : data bits per frame (default receiver parameter)
//   UART_DIV_HALF    : half of the divide-by-650 ratio used by the clock counter
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_DIV_HALF   = 325;

    typedef enum logic [2:0] {
        ST_ARM    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_oversampled_sync.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchronizer with a parameterised reset value.
//   clk   : destination clock
//   reset : synchronous, active-high
//   i_d   : asynchronous input
//   o_q   : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
// 8N1 serial receiver driven by an oversample tick derived from tclk. The tclk
// input is only sampled as data; every FSM and counter advance happens on a
// clk cycle where tclk has just risen.
//   clk          : system clock
//   reset        : synchronous, active-high
//   tclk         : oversample clock (OVERSAMPLE ticks per bit), clk domain
//   rx           : asynchronous serial line, idle high
//   data         : last good byte, held until the next good frame
//   valid        : one-cycle pulse when data updates
//   framing_err  : one-cycle pulse when the stop bit samples low
//   parity_err   : one-cycle pulse on even-parity mismatch (UART_RX_PARITY_EN)
//   busy         : high in every state except IDLE (low out of reset)
// Optional feature macro: UART_RX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
// -----------------------------------------------------------------------------
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tclk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 framing_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    logic                 r_tclk_q;
    logic                 w_tick;
    logic                 w_rx_s;
    rx_state_t            r_state;
    logic [OS_W-1:0]      r_os_cnt;
    logic [BC_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_framing_err;
    logic                 r_busy;
`ifdef UART_RX_PARITY_EN
    logic                 r_parity_err;
    logic                 r_par_bit;
`endif

    // Rising-edge detect on tclk gives exactly one tick per oversample period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tclk_q <= 1'b0;
        end else begin
            r_tclk_q <= tclk;
        end
    end

    assign w_tick = tclk & ~r_tclk_q;

    // Synchronizer resets high so a reset never looks like a start bit.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_ARM;
            r_os_cnt      <= '0;
            r_bit_cnt     <= '0;
            r_shreg       <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_framing_err <= 1'b0;
            r_busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err  <= 1'b0;
            r_par_bit     <= 1'b0;
`endif
        end else begin
            // Status strobes are single-cycle by default.
            r_valid       <= 1'b0;
            r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err  <= 1'b0;
`endif
            if (w_tick) begin
                case (r_state)
                    // Only leave ARM once the line is seen high, so a break
                    // or a stuck-low line cannot retrigger frames.
                    ST_ARM: begin
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end

                    ST_IDLE: begin
                        if (!w_rx_s) begin
                            r_state  <= ST_START;
                            r_os_cnt <= '0;
                            r_busy   <= 1'b1;
                        end
                    end

                    // Re-check the start bit at its centre; a high sample
                    // there means the falling edge was a glitch.
                    ST_START: begin
                        if (r_os_cnt == OS_MID) begin
                            r_os_cnt <= '0;
                            if (!w_rx_s) begin
                                r_state   <= ST_DATA;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end

                    // From the start-bit centre, every full bit period lands
                    // on the centre of the next bit. Shifting in at the MSB
                    // leaves the first-received bit at the LSB.
                    ST_DATA: begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt  <= '0;
                            r_shreg   <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt  <= '0;
                            r_par_bit <= w_rx_s;
                            r_state   <= ST_STOP;
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
`endif

                    // Returning to IDLE at the stop-bit centre leaves half a
                    // bit to catch a back-to-back start edge.
                    ST_STOP: begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt <= '0;
                            if (w_rx_s) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                if ((^r_shreg) != r_par_bit) begin
                                    r_parity_err <= 1'b1;
                                end else begin
                                    r_data  <= r_shreg;
                                    r_valid <= 1'b1;
                                end
`else
                                r_data  <= r_shreg;
                                r_valid <= 1'b1;
`endif
                            end else begin
                                // Framing error wins over any parity result.
                                r_framing_err <= 1'b1;
                                r_state       <= ST_ARM;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end

                    default: begin
                        r_state <= ST_ARM;
                    end
                endcase
            end
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign framing_err = r_framing_err;
    assign busy        = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversampled
// Scoreboard bench for uart_rx_oversampled. Frames are driven bit by bit on
// the bench's own tclk; every driven frame pushes its expected outcome, and a
// negedge monitor pops and compares when the receiver strobes.
// Honours UART_RX_PARITY_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_uart_rx_oversampled;
    import uart_pkg::*;

    localparam logic [2:0] K_V  = 3'b001;
    localparam logic [2:0] K_FE = 3'b010;
    localparam logic [2:0] K_PE = 3'b100;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_EN    = 1'b1;
    localparam int   PAR_TICKS = 16;
`else
    localparam logic PAR_EN    = 1'b0;
    localparam int   PAR_TICKS = 0;
`endif

    typedef struct {
        logic [2:0] kind;
        logic [7:0] b;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       tclk  = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       parity_err;
    logic       busy;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    int   div       = 0;
    logic tclk_prev = 1'b0;
    int   tick_no   = 0;

    logic [7:0] last_good    = 8'h00;
    logic       busy_prev    = 1'b0;
    int         busy_start   = 0;
    int         busy_len     = 0;
    int         last_vtick   = 0;
    int         prev_vtick   = 0;
    logic [2:0] prev_pulse   = 3'b000;

    uart_rx_oversampled dut (
        .clk         (clk),
        .reset       (reset),
        .tclk        (tclk),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .framing_err (framing_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy)
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // Shortened divider (8 clk per tick) keeps the run small.
    always @(posedge clk) begin
        div       <= (div == 7) ? 0 : div + 1;
        tclk      <= (div < 4);
        tclk_prev <= tclk;
        if (tclk && !tclk_prev) tick_no <= tick_no + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge tclk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        exp_t e;
        e.b = b;
        if (!stop_bit)               e.kind = K_FE;
        else if (par_flip & PAR_EN)  e.kind = K_PE;
        else                         e.kind = K_V;
        sb.push_back(e);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        wait_ticks(16);
`endif
        rx = stop_bit;
        wait_ticks(16);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: pulse scoreboard, pulse width, busy span, valid spacing.
    initial begin
        exp_t e;
        logic [2:0] pulses;
        forever begin
            @(negedge clk);
            if (reset) last_good = 8'h00;
            if (busy && !busy_prev) busy_start = tick_no;
            if (!busy && busy_prev) busy_len = tick_no - busy_start;
            busy_prev = busy;
            pulses = {parity_err, framing_err, valid};
            if (pulses != 3'b000) begin
                check_val("pulse_1cyc", 32'(pulses & prev_pulse), 32'd0);
                if (sb.size() == 0) begin
                    check_val("spurious", 32'(pulses), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("kind", 32'(pulses), 32'(e.kind));
                    if (valid) begin
                        check_val("data", 32'(data), 32'(e.b));
                        last_good  = e.b;
                        prev_vtick = last_vtick;
                        last_vtick = tick_no;
                    end else begin
                        check_val("data_hold", 32'(data), 32'(last_good));
                    end
                end
            end
            prev_pulse = pulses;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        pulse_reset();
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_ferr",  32'(framing_err), 32'd0);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_data",  32'(data), 32'd0);
        wait_ticks(4);

        // Single byte and busy span
        send_frame(8'h55, 1'b1, 1'b0);
        wait_ticks(4);
        check_val("busy_len", 32'(busy_len), 32'(152 + PAR_TICKS));

        // Back-to-back bytes
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        wait_ticks(2);
        check_val("b2b_gap", 32'(last_vtick - prev_vtick), 32'(160 + PAR_TICKS));

        // Start glitch: 3 ticks low
        wait_ticks(8);
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(2);
        check_val("glitch_busy_hi", 32'(busy), 32'd1);
        wait_ticks(8);
        check_val("glitch_busy_lo", 32'(busy), 32'd0);

        // Framing error then line held low
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(40);
        check_val("arm_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_ticks(4);
        check_val("rearm_busy", 32'(busy), 32'd0);
        wait_ticks(4);

        // Reset during bit 4 of 0xFF
        rx = 1'b0;
        wait_ticks(16);
        rx = 1'b1;
        wait_ticks(16 * 4 + 8);
        pulse_reset();
        check_val("mid_rst_valid", 32'(valid), 32'd0);
        check_val("mid_rst_ferr",  32'(framing_err), 32'd0);
        check_val("mid_rst_busy",  32'(busy), 32'd0);
        check_val("mid_rst_data",  32'(data), 32'd0);
        wait_ticks(8 + 16 * 3 + PAR_TICKS + 16 + 4);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_ticks(4);

`ifdef UART_RX_PARITY_EN
        // Parity mismatch
        send_frame(8'h07, 1'b1, 1'b1);
        wait_ticks(4);
`endif

        wait_ticks(4);
        check_val("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Serial receiver that consumes the oversample clock produced by the divide-by-650 clock counter (100 MHz / 650 ≈ 153.8 kHz = 16 × 9600 baud). It recovers 8N1 frames from the asynchronous `rx` pin and emits each byte as a one-cycle `valid` strobe in the `clk` domain. It sits between the clock-counter stage and the byte consumer (command decoder / FIFO).

## Interface
- `OVERSAMPLE`, 16, ticks per bit; must be even and ≥ 4.
- `DATA_BITS`, 8, data bits per frame, LSB first.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high; the only reset.
- `tclk`  in  1  oversample clock from the clock counter, generated in the `clk` domain. Sampled as data only, never used as a clock.
- `rx`  in  1  asynchronous serial line; idle high.
- `data`  out  DATA_BITS  last good byte; holds until the next good frame.
- `valid`  out  1  one-`clk` pulse when `data` updates.
- `framing_err`  out  1  one-`clk` pulse when the stop bit samples low.
- `busy`  out  1  high in every state except IDLE.
- `parity_err`  out  1  present only with `UART_RX_PARITY_EN`; one-`clk` pulse.

## Operation
- Tick: `tick = tclk & ~tclk_q`, where `tclk_q` is `tclk` registered on `clk`. There is one tick per rising edge of `tclk`. All state/counter advances occur only on cycles with `tick = 1`.
- `rx` passes through a 2-FF synchronizer (`rx_s`) before any use.
- Counters: `os_cnt` is $clog2(OVERSAMPLE) bits and wraps at OVERSAMPLE-1. `bit_cnt` is $clog2(DATA_BITS+1) bits.
- States are ARM, IDLE, START, DATA, (PARITY), STOP.
  - ARM: wait for `rx_s = 1` on a tick, then go to IDLE. This blocks retrigger during a break or a line held low.
  - IDLE: when `rx_s = 0` on a tick, go to START with `os_cnt` ← 0.
  - START: on `os_cnt = OVERSAMPLE/2 - 1`, check `rx_s`. If it is 0, go to DATA with `os_cnt` ← 0 and `bit_cnt` ← 0. If it is 1, treat it as a glitch and go to IDLE.
  - DATA: on `os_cnt = OVERSAMPLE-1`, shift `rx_s` into `shreg` MSB-first-in so the byte comes out LSB-first, then increment `bit_cnt`. Exit when `bit_cnt = DATA_BITS-1` is sampled.
  - STOP: on `os_cnt = OVERSAMPLE-1`:
    - `rx_s = 1`: `data` ← `shreg`, pulse `valid`, go to IDLE.
    - `rx_s = 0`: pulse `framing_err`, leave `data` unchanged, go to ARM.
- Samples therefore land at mid-bit: tick 8 of the start bit, then every 16 ticks after that.
- Reset values:
  - State is ARM.
  - `data` = 0.
  - `valid`, `framing_err`, `parity_err`, `busy` = 0.
  - `os_cnt`, `bit_cnt`, `shreg`, `tclk_q` = 0.
  - Both synchronizer flops = 1.
- Reset asserted mid-frame abandons the frame with no pulse. The receiver re-arms only after `rx_s` is seen high.
- `valid` and `framing_err` are mutually exclusive. Neither is ever asserted for more than one cycle.

## Timing
- With the nominal divider, one tick occurs every 650 `clk` cycles.
- Latency from the `rx` falling edge to the first tick seen in IDLE: 2-cycle synchronizer, then up to 1 tick period.
- `valid` is registered: it asserts in the `clk` cycle after the tick on which the stop bit was sampled.
- Frame length from the start detect tick to `valid` is `OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1)` ticks = 152 ticks at the defaults.
- Back-to-back frames are supported: IDLE is reached mid-stop-bit, so a start edge half a bit later is caught.
- `tclk` stuck or stopped freezes the FSM in place. No timeout exists.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP and samples one even-parity bit.
  - On a mismatch, `parity_err` pulses at the stop sample and `valid` is suppressed.
  - A framing error takes precedence over a parity error.
- `UART_RX_PARITY_EN` undefined:
  - Frames are 8N1.
  - There is no PARITY state and no `parity_err` port.

## Structure
- Shared package `uart_pkg`:
  - State enum `rx_state_t`.
  - `UART_OVERSAMPLE = 16` and `UART_DATA_BITS = 8`, used as the parameter defaults.
  - `UART_DIV_HALF = 325`, shared with the clock counter.
- One sub-module, `sync_2ff`: a single-bit 2-FF synchronizer with a parameterised reset value. Used for `rx`.

## Test plan
- **Byte 0x55.** Drive 8N1 0x55 at 16 ticks/bit. Expect exactly one `valid` pulse, `data = 8'h55`, `framing_err = 0`, and `busy` high for 152 ticks.
- **Back-to-back bytes.** Drive 0xA3 then 0x0F with no idle gap. Expect two `valid` pulses 160 ticks apart, with `data` = 0xA3 then 0x0F.
- **Start glitch.** Hold `rx` low for 3 ticks in IDLE. Expect a return to IDLE, no `valid`, and `busy` low after the tick-8 check.
- **Framing error.** Send 0x3C with the stop bit low, then hold `rx` low for 40 ticks. Expect one `framing_err` pulse, `data` unchanged, and no new frame until `rx` goes high.
- **Reset mid-frame.** Assert `reset` for 1 cycle during bit 4 of 0xFF. Expect all outputs at 0, no pulse, and a following 0x81 received correctly.
- **Parity error** (only with `UART_RX_PARITY_EN`). Send 0x07 with parity bit 0. Expect a `parity_err` pulse, no `valid`, and `data` unchanged.
